// File: rtl/diff_core_pkg.sv
// rtl/diff_core_pkg.sv - shared types and constants for the feature-map guard controller
package diff_core_pkg;

    // One queued layer: count-1 values per dimension plus the mode bits.
    typedef struct packed {
        logic [7:0] w_num;
        logic [7:0] h_num;
        logic [7:0] c_num;
        logic       kernal_mode;
        logic       bit_mode;
    } fm_layer_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } fm_guard_ctrl_state_t;

    localparam int FM_GUARD_DESC_DEPTH = 4;
    localparam int FM_DESC_W           = $bits(fm_layer_desc_t);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers
// Ports: clk, rst (sync, active-high); push_i/wdata_i write side;
//        pop_i/rdata_o read side (rdata_o shows the head); full_o, empty_o.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fm_guard_ctrl.sv
// rtl/fm_guard_ctrl.sv - queues layer descriptors, issues them to the guard generator, gates psum beats
// Ports: clk, rst (sync, active-high); desc_* descriptor push; gg_* configuration
//        handshake and gg_finish; psum_almost_valid_i/_o raw and gated beat;
//        busy, layer_done, layer_cnt status; err_overrun/err_underrun sticky flags, err_clr.
module fm_guard_ctrl
    import diff_core_pkg::*;
#(
    parameter int DESC_DEPTH = FM_GUARD_DESC_DEPTH,
    parameter int BEAT_W     = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       desc_valid,
    output logic       desc_ready,
    input  logic [7:0] desc_w_num,
    input  logic [7:0] desc_h_num,
    input  logic [7:0] desc_c_num,
    input  logic       desc_kernal_mode,
    input  logic       desc_bit_mode,
    output logic       gg_valid,
    input  logic       gg_ready,
    output logic [7:0] gg_w_num,
    output logic [7:0] gg_h_num,
    output logic [7:0] gg_c_num,
    output logic       gg_kernal_mode,
    output logic       gg_bit_mode,
    input  logic       gg_finish,
    input  logic       psum_almost_valid_i,
    output logic       psum_almost_valid_o,
    output logic       busy,
    output logic       layer_done,
    output logic [7:0] layer_cnt,
    output logic       err_overrun,
    output logic       err_underrun,
    input  logic       err_clr
);
    fm_guard_ctrl_state_t state_q, state_d;
    logic [BEAT_W-1:0]    remaining_q, remaining_d;
    logic [7:0]           layer_cnt_q, layer_cnt_d;
    logic                 err_ov_q, err_ov_d;
    logic                 err_un_q, err_un_d;

    fm_layer_desc_t       push_desc, head_desc;
    logic [FM_DESC_W-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_push, issue_fire;
    logic                 beat_ok, overrun_evt, underrun_evt;
    logic [BEAT_W-1:0]    rem_after_beat, load_val;

    assign push_desc = '{w_num: desc_w_num, h_num: desc_h_num, c_num: desc_c_num,
                         kernal_mode: desc_kernal_mode, bit_mode: desc_bit_mode};
    assign head_desc = fifo_rdata;
    assign fifo_push = desc_valid && !fifo_full;
    assign issue_fire = (state_q == ST_ISSUE) && gg_ready;

    sync_fifo #(
        .WIDTH (FM_DESC_W),
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (push_desc),
        .pop_i   (issue_fire),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Operands widened before multiplying so 256*256*256 does not truncate.
    assign load_val = (BEAT_W'(head_desc.w_num) + BEAT_W'(1))
                    * (BEAT_W'(head_desc.h_num) + BEAT_W'(1))
                    * (BEAT_W'(head_desc.c_num) + BEAT_W'(1));

    // A beat is only legal in RUN with budget left; anything else is an overrun.
    assign beat_ok        = (state_q == ST_RUN) && psum_almost_valid_i && (remaining_q != '0);
    assign overrun_evt    = psum_almost_valid_i && !beat_ok;
    // Same-cycle beat is counted before the finish checks the remaining budget.
    assign rem_after_beat = beat_ok ? (remaining_q - BEAT_W'(1)) : remaining_q;
    assign underrun_evt   = (state_q == ST_RUN) && gg_finish && (rem_after_beat != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            layer_cnt_q <= '0;
            err_ov_q    <= 1'b0;
            err_un_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            layer_cnt_q <= layer_cnt_d;
            err_ov_q    <= err_ov_d;
            err_un_q    <= err_un_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = rem_after_beat;
        layer_cnt_d = layer_cnt_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: if (gg_ready) begin
                          state_d     = ST_RUN;
                          remaining_d = load_val;
                      end
            ST_RUN:   if (gg_finish) state_d = ST_DONE;
            ST_DONE:  begin
                          state_d     = fifo_empty ? ST_IDLE : ST_ISSUE;
                          layer_cnt_d = layer_cnt_q + 8'd1;
                      end
            default:  state_d = ST_IDLE;
        endcase
        // Error events take priority over a same-cycle clear.
        err_ov_d = overrun_evt  || (err_ov_q && !err_clr);
        err_un_d = underrun_evt || (err_un_q && !err_clr);
    end

    always_comb begin
        gg_valid            = (state_q == ST_ISSUE);
        gg_w_num            = gg_valid ? head_desc.w_num : 8'd0;
        gg_h_num            = gg_valid ? head_desc.h_num : 8'd0;
        gg_c_num            = gg_valid ? head_desc.c_num : 8'd0;
        gg_kernal_mode      = gg_valid && head_desc.kernal_mode;
        gg_bit_mode         = gg_valid && head_desc.bit_mode;
        psum_almost_valid_o = beat_ok;
        layer_done          = (state_q == ST_DONE);
        busy                = (state_q != ST_IDLE) || !fifo_empty;
        desc_ready          = !fifo_full;
        layer_cnt           = layer_cnt_q;
        err_overrun         = err_ov_q;
        err_underrun        = err_un_q;
    end

endmodule

// File: tb/tb_fm_guard_ctrl.sv
// tb/tb_fm_guard_ctrl.sv - self-checking bench for fm_guard_ctrl
module tb_fm_guard_ctrl;
    import diff_core_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       desc_valid, desc_ready;
    logic [7:0] desc_w_num, desc_h_num, desc_c_num;
    logic       desc_kernal_mode, desc_bit_mode;
    logic       gg_valid, gg_ready;
    logic [7:0] gg_w_num, gg_h_num, gg_c_num;
    logic       gg_kernal_mode, gg_bit_mode, gg_finish;
    logic       psum_i, psum_o;
    logic       busy, layer_done;
    logic [7:0] layer_cnt;
    logic       err_overrun, err_underrun, err_clr;

    int total = 0;
    int bad   = 0;
    int cnt_m = 0;
    fm_layer_desc_t q[$];

    fm_guard_ctrl dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_w_num(desc_w_num), .desc_h_num(desc_h_num), .desc_c_num(desc_c_num),
        .desc_kernal_mode(desc_kernal_mode), .desc_bit_mode(desc_bit_mode),
        .gg_valid(gg_valid), .gg_ready(gg_ready),
        .gg_w_num(gg_w_num), .gg_h_num(gg_h_num), .gg_c_num(gg_c_num),
        .gg_kernal_mode(gg_kernal_mode), .gg_bit_mode(gg_bit_mode),
        .gg_finish(gg_finish),
        .psum_almost_valid_i(psum_i), .psum_almost_valid_o(psum_o),
        .busy(busy), .layer_done(layer_done), .layer_cnt(layer_cnt),
        .err_overrun(err_overrun), .err_underrun(err_underrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic fm_layer_desc_t mk(input int w, input int h, input int c);
        fm_layer_desc_t d;
        d.w_num       = 8'(w);
        d.h_num       = 8'(h);
        d.c_num       = 8'(c);
        d.kernal_mode = 1'($urandom_range(0, 1));
        d.bit_mode    = 1'($urandom_range(0, 1));
        return d;
    endfunction

    function automatic logic [31:0] gg_pack();
        fm_layer_desc_t g;
        g.w_num = gg_w_num; g.h_num = gg_h_num; g.c_num = gg_c_num;
        g.kernal_mode = gg_kernal_mode; g.bit_mode = gg_bit_mode;
        return 32'(g);
    endfunction

    task automatic drive_desc(input fm_layer_desc_t d);
        desc_w_num = d.w_num; desc_h_num = d.h_num; desc_c_num = d.c_num;
        desc_kernal_mode = d.kernal_mode; desc_bit_mode = d.bit_mode;
    endtask

    task automatic push(input fm_layer_desc_t d);
        chk("desc_ready_before_push", desc_ready, 32'(q.size() < 4));
        drive_desc(d);
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        q.push_back(d);
    endtask

    // Runs the layer at the head of the model queue: issue, nbeats beats, finish.
    task automatic do_layer(input int nbeats, input bit fin_with_beat);
        fm_layer_desc_t d;
        int  n;
        bit  ov;
        bit  last;
        d  = q[0];
        n  = (int'(d.w_num) + 1) * (int'(d.h_num) + 1) * (int'(d.c_num) + 1);
        ov = 1'b0;
        for (int k = 0; k < 6 && gg_valid !== 1'b1; k++) step();
        chk("gg_valid_issue", gg_valid, 1);
        chk("gg_fields", gg_pack(), 32'(d));
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("gg_hold", gg_pack(), 32'(d));
        end
        gg_ready = 1'b1;
        step();
        gg_ready = 1'b0;
        void'(q.pop_front());
        chk("gg_valid_after_accept", gg_valid, 0);
        chk("remaining_load", 32'(dut.remaining_q), 32'(n));
        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(0, 1)) step();
            last = fin_with_beat && (i == nbeats - 1);
            psum_i = 1'b1;
            if (last) gg_finish = 1'b1;
            #1;
            chk("psum_forward", psum_o, 32'(i < n));
            if (i >= n) ov = 1'b1;
            step();
            psum_i    = 1'b0;
            gg_finish = 1'b0;
            if (!last) chk("overrun_flag", err_overrun, 32'(ov));
        end
        if (!(fin_with_beat && nbeats > 0)) begin
            gg_finish = 1'b1;
            step();
            gg_finish = 1'b0;
        end
        chk("layer_done_pulse", layer_done, 1);
        chk("err_overrun_done", err_overrun, 32'(ov));
        chk("err_underrun_done", err_underrun, 32'(nbeats < n));
        cnt_m  = (cnt_m + 1) % 256;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("layer_done_one_cycle", layer_done, 0);
        chk("layer_cnt", layer_cnt, 32'(cnt_m));
        chk("next_issue", gg_valid, 32'(q.size() != 0));
        chk("busy_after_done", busy, 32'(q.size() != 0));
        chk("err_cleared", {err_overrun, err_underrun}, 0);
    endtask

    initial begin
        fm_layer_desc_t d;
        int n, nb;
        rst = 1'b1; desc_valid = 1'b0; gg_ready = 1'b0; gg_finish = 1'b0;
        psum_i = 1'b0; err_clr = 1'b0;
        drive_desc('0);
        repeat (2) step();
        rst = 1'b0;
        chk("rst_gg_valid", gg_valid, 0);
        chk("rst_gg_fields", gg_pack(), 0);
        chk("rst_psum_o", psum_o, 0);
        chk("rst_layer_done", layer_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_desc_ready", desc_ready, 1);
        chk("rst_layer_cnt", layer_cnt, 0);
        chk("rst_errors", {err_overrun, err_underrun}, 0);

        push(mk(1, 1, 0)); do_layer(4, 1'b0);
        push(mk(0, 0, 0)); do_layer(2, 1'b0);
        push(mk(3, 0, 0)); do_layer(2, 1'b0);
        push(mk(1, 0, 0)); do_layer(2, 1'b1);

        // Fill the queue while the issue handshake is stalled.
        for (int i = 0; i < 4; i++) push(mk($urandom_range(0, 3), $urandom_range(0, 2), 0));
        chk("fifo_full_ready_low", desc_ready, 0);
        chk("busy_full", busy, 1);
        drive_desc(mk(7, 7, 7));
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        do_layer(int'(q[0].w_num + 1) * int'(q[0].h_num + 1), 1'b0);
        push(mk(2, 1, 1));
        for (int i = 0; i < 4; i++) begin
            d = q[0];
            do_layer((int'(d.w_num) + 1) * (int'(d.h_num) + 1) * (int'(d.c_num) + 1), 1'b0);
        end

        // Beat while idle: never forwarded, counts as overrun even with a clear.
        psum_i = 1'b1; err_clr = 1'b1;
        #1;
        chk("idle_psum_blocked", psum_o, 0);
        step();
        psum_i = 1'b0;
        chk("overrun_beats_clear", err_overrun, 1);
        step();
        err_clr = 1'b0;
        chk("overrun_cleared", err_overrun, 0);

        for (int l = 0; l < 6; l++) begin
            d  = mk($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
            n  = (int'(d.w_num) + 1) * (int'(d.h_num) + 1) * (int'(d.c_num) + 1);
            nb = n - 1 + int'($urandom_range(0, 2));
            push(d);
            do_layer(nb, (nb > 0) && ($urandom_range(0, 1) == 1));
        end

        // Largest layer, then a reset mid-layer with descriptors queued.
        push(mk(255, 255, 255));
        for (int k = 0; k < 6 && gg_valid !== 1'b1; k++) step();
        chk("big_issue", gg_valid, 1);
        gg_ready = 1'b1;
        step();
        gg_ready = 1'b0;
        void'(q.pop_front());
        chk("big_remaining", 32'(dut.remaining_q), 32'd16777216);
        for (int i = 0; i < 3; i++) begin
            psum_i = 1'b1;
            #1;
            chk("big_psum_fwd", psum_o, 1);
            step();
        end
        psum_i = 1'b0;
        chk("big_remaining_dec", 32'(dut.remaining_q), 32'd16777213);
        push(mk(1, 1, 1));
        push(mk(2, 2, 2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        cnt_m = 0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_desc_ready", desc_ready, 1);
        chk("rstmid_layer_done", layer_done, 0);
        chk("rstmid_gg_valid", gg_valid, 0);
        chk("rstmid_layer_cnt", layer_cnt, 0);
        step();
        chk("rstmid_no_done", layer_done, 0);
        chk("rstmid_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
